// File: rtl/time_keeper.sv
// time_keeper
//
// Timekeeping front end for the LCD clock. Qualifies the raw one-minute
// strobe pin, keeps a 24-hour BCD HH:MM count, and serves it as five ASCII
// characters ("HH:MM") through a registered request/acknowledge read port.
//
// Ports
//   clk          system clock (single domain)
//   reset        synchronous, active-high reset
//   stb_1min     raw asynchronous minute strobe
//   set_valid    one-cycle load request for set_hh/set_mm
//   set_hh       BCD hours to load   {tens, ones}
//   set_mm       BCD minutes to load {tens, ones}
//   set_err      one-cycle pulse after a rejected load
//   rd_req       character read request (one read per cycle while high)
//   rd_idx       character index: 0..4 = H H : M M, 5..7 = space
//   rd_data      ASCII character, held until the next read
//   rd_ack       one-cycle pulse, rd_data valid while high
//   changed      level, set by any time update, forced high by reset
//   changed_clr  clears changed (an update in the same cycle wins)

module time_keeper #(
    parameter int unsigned CLOCK_RATE  = 1000,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned MIN_HIGH    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       stb_1min,
    input  logic       set_valid,
    input  logic [7:0] set_hh,
    input  logic [7:0] set_mm,
    output logic       set_err,
    input  logic       rd_req,
    input  logic [2:0] rd_idx,
    output logic [7:0] rd_data,
    output logic       rd_ack,
    output logic       changed,
    input  logic       changed_clr
);

    if (CLOCK_RATE == 0 || SYNC_STAGES < 2 || SYNC_STAGES > 3 ||
        MIN_HIGH < 1 || MIN_HIGH > 15) begin : g_param_check
        $error("time_keeper: illegal parameter value");
    end

    localparam logic [3:0] MinHighC = 4'(MIN_HIGH);
    localparam logic [7:0] ChSpace  = 8'h20;
    localparam logic [7:0] ChColon  = 8'h3A;

    function automatic logic [7:0] digit_char(input logic [3:0] v);
        return {4'h3, v};
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic [3:0]             run_q,  run_d;
    logic [3:0]             hh_t_q, hh_t_d;
    logic [3:0]             hh_o_q, hh_o_d;
    logic [3:0]             mm_t_q, mm_t_d;
    logic [3:0]             mm_o_q, mm_o_d;
    logic [15:0]            snap_q, snap_d;
    logic [7:0]             rd_data_q, rd_data_d;
    logic                   rd_ack_q;
    logic                   set_err_q;
    logic                   changed_q, changed_d;

    logic s;
    logic accept;
    logic set_ok;
    logic update;

    assign s = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Strobe qualification: the counter saturates at MIN_HIGH, so the
    // MIN_HIGH-1 -> MIN_HIGH step occurs exactly once per high run.
    // ------------------------------------------------------------------
    always_comb begin
        run_d  = run_q;
        accept = 1'b0;
        if (!s) begin
            run_d = '0;
        end else if (run_q != MinHighC) begin
            run_d  = run_q + 4'd1;
            accept = (run_q == MinHighC - 4'd1);
        end
    end

    // ------------------------------------------------------------------
    // Load validation and time next-state
    // ------------------------------------------------------------------
    always_comb begin
        set_ok = (set_mm[7:4] <= 4'd5) && (set_mm[3:0] <= 4'd9) &&
                 (set_hh[3:0] <= 4'd9) &&
                 ((set_hh[7:4] < 4'd2) ||
                  ((set_hh[7:4] == 4'd2) && (set_hh[3:0] <= 4'd3)));
    end

    always_comb begin
        hh_t_d = hh_t_q;
        hh_o_d = hh_o_q;
        mm_t_d = mm_t_q;
        mm_o_d = mm_o_q;
        update = 1'b0;
        if (set_valid) begin
            // A load request always discards a coincident accept.
            if (set_ok) begin
                hh_t_d = set_hh[7:4];
                hh_o_d = set_hh[3:0];
                mm_t_d = set_mm[7:4];
                mm_o_d = set_mm[3:0];
                update = 1'b1;
            end
        end else if (accept) begin
            update = 1'b1;
            if (mm_o_q == 4'd9) begin
                mm_o_d = '0;
                if (mm_t_q == 4'd5) begin
                    mm_t_d = '0;
                    if (hh_t_q == 4'd2 && hh_o_q == 4'd3) begin
                        hh_t_d = '0;
                        hh_o_d = '0;
                    end else if (hh_o_q == 4'd9) begin
                        hh_o_d = '0;
                        hh_t_d = hh_t_q + 4'd1;
                    end else begin
                        hh_o_d = hh_o_q + 4'd1;
                    end
                end else begin
                    mm_t_d = mm_t_q + 4'd1;
                end
            end else begin
                mm_o_d = mm_o_q + 4'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read port: index 0 captures the live (pre-update) time into the
    // snapshot; indices 1..4 read only the snapshot so a 0..4 frame
    // never mixes two different times.
    // ------------------------------------------------------------------
    always_comb begin
        snap_d    = snap_q;
        rd_data_d = rd_data_q;
        if (rd_req) begin
            unique case (rd_idx)
                3'd0: begin
                    snap_d    = {hh_t_q, hh_o_q, mm_t_q, mm_o_q};
                    rd_data_d = digit_char(hh_t_q);
                end
                3'd1:    rd_data_d = digit_char(snap_q[11:8]);
                3'd2:    rd_data_d = ChColon;
                3'd3:    rd_data_d = digit_char(snap_q[7:4]);
                3'd4:    rd_data_d = digit_char(snap_q[3:0]);
                default: rd_data_d = ChSpace;
            endcase
        end
    end

    always_comb begin
        if (update) begin
            changed_d = 1'b1;
        end else if (changed_clr) begin
            changed_d = 1'b0;
        end else begin
            changed_d = changed_q;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q    <= '0;
            run_q     <= '0;
            hh_t_q    <= '0;
            hh_o_q    <= '0;
            mm_t_q    <= '0;
            mm_o_q    <= '0;
            snap_q    <= '0;
            rd_data_q <= ChSpace;
            rd_ack_q  <= 1'b0;
            set_err_q <= 1'b0;
            changed_q <= 1'b1;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], stb_1min};
            run_q     <= run_d;
            hh_t_q    <= hh_t_d;
            hh_o_q    <= hh_o_d;
            mm_t_q    <= mm_t_d;
            mm_o_q    <= mm_o_d;
            snap_q    <= snap_d;
            rd_data_q <= rd_data_d;
            rd_ack_q  <= rd_req;
            set_err_q <= set_valid && !set_ok;
            changed_q <= changed_d;
        end
    end

    assign rd_data = rd_data_q;
    assign rd_ack  = rd_ack_q;
    assign set_err = set_err_q;
    assign changed = changed_q;

endmodule

// File: tb/tb_time_keeper.sv
// tb_time_keeper
//
// Drives time_keeper with directed scenarios followed by a randomized phase.
// A behavioural model tracks the time as minutes-of-day and qualifies the
// strobe from the history of sampled pin values.

module tb_time_keeper;

    localparam int unsigned SYNC = 2;
    localparam int unsigned MINH = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       stb_1min;
    logic       set_valid;
    logic [7:0] set_hh;
    logic [7:0] set_mm;
    logic       set_err;
    logic       rd_req;
    logic [2:0] rd_idx;
    logic [7:0] rd_data;
    logic       rd_ack;
    logic       changed;
    logic       changed_clr;

    always #5 clk = ~clk;

    time_keeper #(
        .CLOCK_RATE (1000),
        .SYNC_STAGES(SYNC),
        .MIN_HIGH   (MINH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .stb_1min   (stb_1min),
        .set_valid  (set_valid),
        .set_hh     (set_hh),
        .set_mm     (set_mm),
        .set_err    (set_err),
        .rd_req     (rd_req),
        .rd_idx     (rd_idx),
        .rd_data    (rd_data),
        .rd_ack     (rd_ack),
        .changed    (changed),
        .changed_clr(changed_clr)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int         m_min;
    int         m_snap;
    bit         m_changed;
    bit         m_ack;
    bit         m_err;
    logic [7:0] m_data;
    bit         hist_h[$];   // sampled pin per edge, 0 on reset edges
    bit         hist_r[$];   // reset asserted per edge

    function automatic logic [7:0] ch(input int m, input int idx);
        int hrs;
        int mins;
        hrs  = m / 60;
        mins = m % 60;
        case (idx)
            0:       return 8'(48 + hrs / 10);
            1:       return 8'(48 + hrs % 10);
            2:       return 8'h3A;
            3:       return 8'(48 + mins / 10);
            4:       return 8'(48 + mins % 10);
            default: return 8'h20;
        endcase
    endfunction

    function automatic bit legal(input logic [7:0] hh, input logic [7:0] mm);
        int ht, ho, mt, mo;
        ht = int'(hh[7:4]); ho = int'(hh[3:0]);
        mt = int'(mm[7:4]); mo = int'(mm[3:0]);
        return (ho <= 9) && (mo <= 9) && (mt <= 5) && (ht * 10 + ho <= 23);
    endfunction

    function automatic int value_of(input logic [7:0] hh, input logic [7:0] mm);
        return (int'(hh[7:4]) * 10 + int'(hh[3:0])) * 60 + int'(mm[7:4]) * 10 + int'(mm[3:0]);
    endfunction

    function automatic bit hget(input int i);
        return (i < 0) ? 1'b0 : hist_h[i];
    endfunction

    // A strobe is qualified at edge e when the pin was sampled high for
    // MINH consecutive edges after a low sample, ending SYNC edges earlier,
    // with no reset since the end of that window.
    function automatic bit qualified();
        int e, w_end, w0;
        e     = hist_h.size() - 1;
        w_end = e - int'(SYNC);
        w0    = w_end - int'(MINH) + 1;
        for (int i = w_end + 1; i <= e; i++)
            if (i >= 0 && hist_r[i]) return 1'b0;
        for (int i = w0; i <= w_end; i++)
            if (!hget(i)) return 1'b0;
        return !hget(w0 - 1);
    endfunction

    task automatic model_edge();
        bit acc, upd;
        hist_h.push_back(reset ? 1'b0 : stb_1min);
        hist_r.push_back(reset);
        if (reset) begin
            m_min = 0; m_snap = 0; m_changed = 1'b1;
            m_ack = 1'b0; m_err = 1'b0; m_data = 8'h20;
            return;
        end
        acc   = qualified();
        m_ack = rd_req;
        if (rd_req) begin
            if (rd_idx == 3'd0) m_snap = m_min;
            m_data = ch(m_snap, int'(rd_idx));
        end
        m_err = set_valid && !legal(set_hh, set_mm);
        upd   = 1'b0;
        if (set_valid) begin
            if (legal(set_hh, set_mm)) begin
                m_min = value_of(set_hh, set_mm);
                upd   = 1'b1;
            end
        end else if (acc) begin
            m_min = (m_min + 1) % 1440;
            upd   = 1'b1;
        end
        if (upd) m_changed = 1'b1;
        else if (changed_clr) m_changed = 1'b0;
    endtask

    // One clock: model follows the edge, outputs compared 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("rd_ack",  rd_ack,  m_ack);
        chk("set_err", set_err, m_err);
        chk("changed", changed, m_changed);
        chk("rd_data", rd_data, m_data);
        set_valid   = 1'b0;
        rd_req      = 1'b0;
        changed_clr = 1'b0;
    endtask

    task automatic do_read(input int idx, input logic [7:0] exp, input string tag);
        rd_req = 1'b1;
        rd_idx = 3'(idx);
        step();
        chk(tag, rd_data, exp);
    endtask

    task automatic read_time(input string s);
        for (int i = 0; i < 5; i++) do_read(i, s[i], {"frame_", s});
    endtask

    task automatic do_set(input logic [7:0] hh, input logic [7:0] mm);
        set_valid = 1'b1;
        set_hh    = hh;
        set_mm    = mm;
        step();
    endtask

    task automatic pulse(input int n);
        stb_1min = 1'b1;
        repeat (n) step();
        stb_1min = 1'b0;
        repeat (SYNC + MINH + 2) step();
    endtask

    initial begin
        reset = 1'b1; stb_1min = 1'b0; set_valid = 1'b0; set_hh = '0; set_mm = '0;
        rd_req = 1'b0; rd_idx = '0; changed_clr = 1'b0;
        m_min = 0; m_snap = 0; m_changed = 1'b1; m_ack = 1'b0; m_err = 1'b0; m_data = 8'h20;

        repeat (3) step();
        reset = 1'b0;
        read_time("00:00");
        chk("changed_after_reset", changed, 1);
        changed_clr = 1'b1; step();
        chk("changed_cleared", changed, 0);

        do_set(8'h23, 8'h59);
        changed_clr = 1'b1; step();
        pulse(6);
        read_time("00:00");
        chk("changed_after_wrap", changed, 1);
        do_set(8'h09, 8'h59);
        pulse(6);
        read_time("10:00");

        pulse(1);   read_time("10:00");
        pulse(4);   read_time("10:01");
        pulse(100); read_time("10:02");

        do_set(8'h12, 8'h34);
        do_read(0, 8'h31, "snap_h_t");
        pulse(6);
        do_read(1, 8'h32, "snap_h_o");
        do_read(2, 8'h3A, "snap_colon");
        do_read(3, 8'h33, "snap_m_t");
        do_read(4, 8'h34, "snap_m_o");
        do_read(0, 8'h31, "reread_h_t");
        do_read(4, 8'h35, "reread_m_o");

        do_set(8'h12, 8'h60);
        chk("set_err_mm60", set_err, 1);
        step();
        chk("set_err_once", set_err, 0);
        do_set(8'h24, 8'h00);
        chk("set_err_hh24", set_err, 1);
        read_time("12:35");

        // load coincides with the accept edge
        stb_1min = 1'b1;
        repeat (SYNC + MINH - 1) step();
        do_set(8'h07, 8'h15);
        stb_1min = 1'b0;
        repeat (6) step();
        read_time("07:15");

        // clear coincides with the accept edge
        changed_clr = 1'b1; step();
        stb_1min = 1'b1;
        repeat (SYNC + MINH - 1) step();
        changed_clr = 1'b1; step();
        chk("changed_clr_vs_accept", changed, 1);
        stb_1min = 1'b0;
        repeat (4) step();
        read_time("07:16");

        // reset in the middle of a high strobe
        stb_1min = 1'b1;
        repeat (3) step();
        reset = 1'b1; repeat (2) step();
        reset = 1'b0; repeat (10) step();
        stb_1min = 1'b0; repeat (4) step();
        read_time("00:01");

        // randomized phase
        begin
            int run_left;
            run_left = 0;
            for (int c = 0; c < 3000; c++) begin
                if (run_left == 0) begin
                    stb_1min = ~stb_1min;
                    run_left = ($urandom % 8 == 0) ? int'($urandom_range(10, 40))
                                                   : int'($urandom_range(1, 7));
                end
                run_left--;
                rd_req      = ($urandom % 3 == 0);
                rd_idx      = 3'($urandom % 8);
                changed_clr = ($urandom % 8 == 0);
                reset       = ($urandom % 500 == 0);
                if ($urandom % 30 == 0) begin
                    set_valid = 1'b1;
                    if ($urandom % 2 == 0) begin
                        set_hh = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 9))};
                        set_mm = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
                    end else begin
                        set_hh = 8'($urandom);
                        set_mm = 8'($urandom);
                    end
                end
                step();
            end
            reset    = 1'b0;
            stb_1min = 1'b0;
            repeat (8) step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/time_keeper.md
# time_keeper

Upstream timekeeping stage for the 1 kHz TinyTapeout LCD clock. Takes the raw external one-minute strobe pin, synchronises and qualifies it, and maintains a 24-hour BCD HH:MM count. Presents the count as five ASCII characters through a request/acknowledge read port and a change flag. The LCD driver consumes both to redraw the display, replacing its direct use of the raw strobe.

## Interface
- CLOCK_RATE, 1000: system clock in Hz; informational only, no logic depends on it.
- SYNC_STAGES, 2: flip-flop stages on the strobe pin; legal values are 2–3.
- MIN_HIGH, 2: consecutive synchronised-high cycles required to accept a strobe; legal values are 1–15.

Ports:
- clk  in  1  system clock; one clock domain.
- reset  in  1  synchronous, active-high reset.
- stb_1min  in  1  raw asynchronous minute strobe pin.
- set_valid  in  1  one-cycle load of set_hh/set_mm.
- set_hh  in  8  BCD hours to load, {tens,ones}.
- set_mm  in  8  BCD minutes to load, {tens,ones}.
- set_err  out  1  one-cycle pulse when a load is rejected.
- rd_req  in  1  character read request.
- rd_idx  in  3  character index, 0..4.
- rd_data  out  8  ASCII character.
- rd_ack  out  1  one-cycle pulse; rd_data is valid while high.
- changed  out  1  level, set when the time changes.
- changed_clr  in  1  clears changed.

## Operation
- Strobe path: stb_1min passes through a SYNC_STAGES synchroniser to give s.
- A 4-bit run counter counts cycles with s=1 and saturates at MIN_HIGH. It clears when s=0.
- One accept occurs on the cycle the run counter reaches MIN_HIGH. There are no further accepts until s has returned to 0.
- Time register: hh_t/hh_o/mm_t/mm_o, each 4-bit BCD.
- Increment sequence: mm_o 9→0 carries into mm_t; mm_t 5→0 carries into the hour.
- Hour increment: hh_o 9→0 carries into hh_t. 23:59 wraps to 00:00.
- Set load is accepted only if mm_t≤5, mm_o≤9, hh_o≤9 and the value is ≤23.
- A rejected load leaves the time unchanged and pulses set_err the next cycle.
- set_valid and an accept in the same cycle: the set wins and the accept is discarded.
- changed is set by any time update, whether accept or valid set.
- changed_clr clears changed; if an update occurs in the same cycle, the set wins.
- Read port: rd_req with rd_idx=0 copies the live time into a snapshot register. rd_data returns the hours-tens character from that new snapshot.
- Indices 1..4 read the snapshot only: 1 = hours ones, 2 = ':' (0x3A), 3 = minutes tens, 4 = minutes ones. This keeps a 0..4 frame tear-free.
- Digit characters are 0x30 + BCD value. Index 5..7 returns 0x20.
- rd_req held high issues one read per cycle; each read is acked.

## Timing
- Reset values: time 00:00, snapshot 00:00, changed=1 (forces the initial draw), rd_ack=0, rd_data=0x20, set_err=0, synchroniser and run counter 0.
- Reset asserted mid-strobe: everything clears. A strobe still high after reset release needs a fresh MIN_HIGH run and is accepted once.
- Strobe latency: if stb_1min is first sampled high at edge 1, the time updates at edge SYNC_STAGES+MIN_HIGH. changed is visible after that same edge.
- A strobe shorter than SYNC_STAGES+MIN_HIGH-1 cycles may be lost. Minimum guaranteed pulse is SYNC_STAGES+MIN_HIGH cycles.
- Set: the time updates on the edge sampling set_valid. set_err pulses on the following edge.
- Read: request at edge N gives rd_data/rd_ack after edge N+1. rd_data holds its value until the next read.
- No back-pressure: the consumer must accept rd_data on the rd_ack cycle.

## Test plan
- Reset, then read indices 0..4 → "00:00" (0x30,0x30,0x3A,0x30,0x30), changed=1. Pulse changed_clr → changed=0.
- set 23:59, then one 6-cycle strobe → time 00:00, changed=1 at edge SYNC_STAGES+MIN_HIGH, single increment only. Repeat from 09:59 → "10:00".
- Glitch of 1 cycle → no change. 4-cycle strobe with defaults → +1 minute. 100-cycle strobe → exactly +1.
- Read idx 0 at 12:34, strobe accepted, then read idx 1..4 → "2:34" from the snapshot. Re-read idx 0 → 0x31 ('1'), then idx 4 → 0x35 ('5').
- set_valid with mm=0x60, then with hh=0x24 → time unchanged, set_err pulses once each. set_valid in the same cycle as an accept → loaded value exactly, no increment.
- changed_clr in the same cycle as an accept → changed stays 1. Reset asserted during a high strobe → 00:00, followed by one accept after release.
